multicycle_adder: RTL

Parametrised sequential adder that computes A + B + Cin over WIDTH/CHUNK clock cycles, CHUNK bits per cycle, LSB slice first. It is the successor to the combinational 16-bit ripple adder. It trades latency for a CHUNK-bit carry chain and adds a Start/Busy/Done handshake so a controller FSM can sequence operations.

---
 rtl/multicycle_adder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/multicycle_adder.sv
// Sequential adder: A + B + Cin over WIDTH/CHUNK cycles, CHUNK bits per cycle, LSB slice first.
// Optional feature macro MULTICYCLE_ADDER_OVF_EN adds the registered signed-overflow output Ovf.
module multicycle_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             Busy,
`ifdef MULTICYCLE_ADDER_OVF_EN
  output logic             Done,
  output logic             Ovf
`else
  output logic             Done
`endif
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic [CHUNK:0]   w_slice;
  logic [WIDTH-1:0] w_acc_next;

  // Next-state logic: Start is only honoured in IDLE or DONE.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_accept     = Start;
        w_next_state = Start ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        w_last = (r_cnt == LAST_SLICE);
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register with Busy/Done registered from the next state.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      Busy    <= (w_next_state == S_RUN);
      Done    <= (w_next_state == S_DONE);
    end
  end

  // Operands shift right each cycle so the current slice is always the low CHUNK bits;
  // finished slices enter the accumulator from the top and end up in order.
  assign w_slice    = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + (CHUNK+1)'(r_carry);
  assign w_acc_next = WIDTH'({w_slice[CHUNK-1:0], r_acc} >> CHUNK);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      Sum     <= '0;
      CO      <= 1'b0;
    end else if (w_accept) begin
      r_a     <= A;
      r_b     <= B;
      r_carry <= Cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> CHUNK;
      r_b     <= r_b >> CHUNK;
      r_carry <= w_slice[CHUNK];
      r_acc   <= w_acc_next;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        Sum <= w_acc_next;
        CO  <= w_slice[CHUNK];
      end
    end
  end

`ifdef MULTICYCLE_ADDER_OVF_EN
  logic r_a_msb;
  logic r_b_msb;

  // Operand MSBs are kept aside because the operand registers are shifted away.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      Ovf     <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= A[WIDTH-1];
      r_b_msb <= B[WIDTH-1];
    end else if (w_last) begin
      Ovf <= (r_a_msb == r_b_msb) && (w_acc_next[WIDTH-1] != r_a_msb);
    end
  end
`endif

endmodule
